cache_fill_ctrl: RTL
====================

// Module: cache_fill_ctrl
// PURPOSE
// Parametrised cache-line fill controller between the cache miss logic and pipelined main memory.
// On a miss it latches the miss address and issues one word request per cycle for the whole line.
// Each returning word is steered into the data array with its word index.
// The tag is written with the last word.
// Request and response counters are independent, so memory latency is not a parameter.
// CONFIGURATION adds optional critical-word-first ordering.
// PARAMETERS
// ADDR_W          16  byte-address width
// DATA_W          16  memory word width in bits, a multiple of 8
// WORDS_PER_LINE  8   words per cache line; power of two, >= 2
// PORTS
// clk                clk  in   1               rising-edge clock
// rst                in   1                    asynchronous reset, active high
// miss_detected      in   1                    cache miss this cycle; sampled only in IDLE
// miss_address       in   ADDR_W               byte address of the missing access
// memory_data_valid  in   1                    one returning word this cycle
// memory_data        in   DATA_W               returning word
// fsm_busy           out  1                    stall the pipeline
// state              out  2                    current FSM state encoding
// mem_req            out  1                    request valid this cycle
// memory_address     out  ADDR_W               word-aligned request address
// write_data_array   out  1                    write one word into the data array
// write_word         out  WW=$clog2(WORDS_PER_LINE)  word index for the write
// write_data         out  DATA_W               equals memory_data (combinational)
// write_tag_array    out  1                    write tag and valid bit
// fill_tag           out  ADDR_W-OFF           latched line tag; OFF = WW + $clog2(DATA_W/8)
// fill_done          out  1                    one-cycle pulse after the fill completes
// crit_word_valid    out  1                    pulse when the critical word is written
// protocol_err       out  1                    sticky flag for a response with nothing outstanding
// BEHAVIOUR
// - Reset (async): state=IDLE, counters=0, latched address=0.
//   All outputs are 0 except write_data and fill_tag.
//   Reset mid-fill abandons the fill. Memory must be reset together with this block.
// - States: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
// - IDLE: miss_detected=1 latches miss_address and clears both counters. Next state is ISSUE.
// - ISSUE: mem_req=1 every cycle.
//   memory_address = {line, word_idx, OFF-WW zero bits}.
//   The request counter increments each cycle.
//   After WORDS_PER_LINE requests, go to WAIT; if the final response has also arrived, go to DONE.
// - WAIT: no requests; keep accepting responses.
// - Responses, accepted in ISSUE or WAIT while resp_cnt < req_issued:
//   - write_data_array=1 and write_word = response word index, in the same cycle as the response.
//   - The response counter increments.
//   - On the last word, write_tag_array=1 in that same cycle. Next state is DONE.
// - DONE: fill_done=1 for one cycle. Next state is IDLE.
// - fsm_busy = (state!=IDLE) | miss_detected.
// - A miss asserted in IDLE at cycle t gives requests at t+1..t+W.
//   Tag write coincides with the last response. fill_done is one cycle later.
// - Boundary conditions:
//   - A response in IDLE or DONE, or with resp_cnt==req_issued, is ignored and sets protocol_err.
//   - miss_detected while not in IDLE is ignored; the cache re-presents it after the stall.
//   - A response in the same cycle as the last request is legal and counted.
//   - Counters wrap modulo WORDS_PER_LINE. A separate done bit marks the completed count; there is no extra counter width.
// CONFIGURATION
// - CACHE_FILL_CWF_EN defined:
//   - The start word is miss_address[OFF-1:OFF-WW].
//   - Request and response word index = (start + count) mod WORDS_PER_LINE.
//   - crit_word_valid pulses with the first data write.
// - CACHE_FILL_CWF_EN undefined:
//   - The start word is 0.
//   - crit_word_valid is tied to 0.
//   - Port list is identical.
// STRUCTURE
// - Package cache_fill_pkg holds the state encodings (IDLE/ISSUE/WAIT/DONE), the state width constant, and the WW/OFF calculation functions.
// - Sub-module cache_fill_counter: WW-bit counter with inc, sync clear, wrap and a done flag.
//   Two instances, for requests and for responses.
// - All registers use the codebase dff cell with rst tied to the rst port.
// TESTING
// - Defaults; miss at 0xABC6; memory latency 4 -> requests 0xABC0..0xABCE on 8 consecutive cycles.
//   write_word 0..7 follows. Tag write coincides with the 8th write. fill_done follows one cycle later.
// - Memory latency 1 (response in the same cycle as the last request) -> ISSUE goes straight to DONE.
//   Exactly 8 writes.
// - memory_data_valid in IDLE -> no write. protocol_err=1 and stays 1 until rst.
// - Second miss during a fill -> ignored. fsm_busy stays 1.
//   A new fill starts only once the state is back in IDLE.
// - rst pulse after 3 responses -> all outputs 0 at once. A new miss then gives a clean 8-word fill.
// - With CACHE_FILL_CWF_EN, miss at 0x1236 -> word order 3,4,5,6,7,0,1,2, first address 0x1236.
//   crit_word_valid pulses with word 3.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared definitions for the cache line fill controller.
// FSM state encodings, state width and the word-index / offset width helpers.
package cache_fill_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to index a word inside a line.
  function automatic int calc_ww(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits needed to index a byte inside a word.
  function automatic int calc_bw(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Total line offset width in a byte address.
  function automatic int calc_off(input int words_per_line, input int data_w);
    return calc_ww(words_per_line) + calc_bw(data_w);
  endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// WW-bit word counter for the fill controller.
// Wraps modulo 2**WW; the done flag marks that a full line has been counted,
// so the completed count needs no extra counter bit. Sync clear has priority.
module cache_fill_counter #(
  parameter int WW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [WW-1:0] count,
  output logic          done
);

  logic [WW-1:0] count_d;
  logic          done_d;

  // Next count: clear, else increment with wrap and set done on the wrap.
  always_comb begin
    count_d = count;
    done_d  = done;
    if (clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (inc) begin
      count_d = count + 1'b1;
      if (&count) done_d = 1'b1;
    end
  end

  dff #(.W(WW)) u_count (.clk(clk), .rst(rst), .d(count_d), .q(count));
  dff #(.W(1))  u_done  (.clk(clk), .rst(rst), .d(done_d),  .q(done));

endmodule

// File: rtl/dff.sv
// Codebase register cell: W-bit D flip-flop, asynchronous active-high reset to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller.
// Latches the miss address, issues one word request per cycle for the whole
// line, steers each returning word into the data array and writes the tag
// with the last word. Request and response counters run independently so any
// memory latency (including a same-cycle response) is handled.
// Optional critical-word-first ordering: define CACHE_FILL_CWF_EN.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                miss_detected,
  input  logic [ADDR_W-1:0]                                   miss_address,
  input  logic                                                memory_data_valid,
  input  logic [DATA_W-1:0]                                   memory_data,
  output logic                                                fsm_busy,
  output logic [STATE_W-1:0]                                  state,
  output logic                                                mem_req,
  output logic [ADDR_W-1:0]                                   memory_address,
  output logic                                                write_data_array,
  output logic [calc_ww(WORDS_PER_LINE)-1:0]                  write_word,
  output logic [DATA_W-1:0]                                   write_data,
  output logic                                                write_tag_array,
  output logic [ADDR_W-calc_off(WORDS_PER_LINE, DATA_W)-1:0]  fill_tag,
  output logic                                                fill_done,
  output logic                                                crit_word_valid,
  output logic                                                protocol_err
);

  localparam int WW    = calc_ww(WORDS_PER_LINE);
  localparam int BW    = calc_bw(DATA_W);
  localparam int OFF   = WW + BW;
  localparam int TAG_W = ADDR_W - OFF;

  state_t              state_q, state_d;
  logic [STATE_W-1:0]  state_raw;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WW-1:0]       start_w;
  logic [WW-1:0]       req_cnt, resp_cnt, req_idx, resp_idx;
  logic                req_done, resp_done;
  logic                load, req_inc, resp_ok, accept;
  logic                req_last, resp_last;
  logic                err_q, err_d;
  logic                unused_addr;

  // Only the tag (and the start word when enabled) of the miss address is kept.
  assign unused_addr = ^miss_address[OFF-1:0];

  dff #(.W(STATE_W)) u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_raw));
  assign state_q = state_t'(state_raw);

  assign load  = (state_q == IDLE) && miss_detected;
  assign tag_d = load ? miss_address[ADDR_W-1:OFF] : tag_q;

  dff #(.W(TAG_W)) u_tag (.clk(clk), .rst(rst), .d(tag_d), .q(tag_q));

`ifdef CACHE_FILL_CWF_EN
  logic [WW-1:0] start_q, start_d;

  assign start_d = load ? miss_address[OFF-1:BW] : start_q;
  dff #(.W(WW)) u_start (.clk(clk), .rst(rst), .d(start_d), .q(start_q));

  assign start_w         = start_q;
  assign crit_word_valid = accept && (resp_cnt == '0);
`else
  assign start_w         = '0;
  assign crit_word_valid = 1'b0;
`endif

  assign req_inc = (state_q == ISSUE);

  cache_fill_counter #(.WW(WW)) u_req_cnt (
    .clk(clk), .rst(rst), .clr(load), .inc(req_inc),
    .count(req_cnt), .done(req_done)
  );

  cache_fill_counter #(.WW(WW)) u_resp_cnt (
    .clk(clk), .rst(rst), .clr(load), .inc(accept),
    .count(resp_cnt), .done(resp_done)
  );

  assign req_idx  = start_w + req_cnt;
  assign resp_idx = start_w + resp_cnt;

  // A response is outstanding in ISSUE if it does not overtake the request
  // issued this cycle; in WAIT every request is out, so any missing word is.
  always_comb begin
    resp_ok = 1'b0;
    case (state_q)
      ISSUE:   resp_ok = !resp_done && (resp_cnt <= req_cnt);
      WAIT:    resp_ok = !resp_done && req_done;
      default: resp_ok = 1'b0;
    endcase
  end

  assign accept    = memory_data_valid && resp_ok;
  assign req_last  = (state_q == ISSUE) && (&req_cnt);
  assign resp_last = accept && (&resp_cnt);

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (req_last) state_d = resp_last ? DONE : WAIT;
      end
      WAIT: begin
        if (resp_last) state_d = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_q | (memory_data_valid & ~accept);
  dff #(.W(1)) u_err (.clk(clk), .rst(rst), .d(err_d), .q(err_q));

  assign memory_address   = mem_req ? (ADDR_W'({tag_q, req_idx}) << BW) : '0;
  assign write_data_array = accept;
  assign write_word       = accept ? resp_idx : '0;
  assign write_data       = memory_data;
  assign write_tag_array  = resp_last;
  assign fill_tag         = tag_q;
  assign protocol_err     = err_q;
  assign state            = state_q;
  assign fsm_busy         = (state_q != IDLE) | miss_detected;

endmodule
